rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 22 ++
 rtl/rf_onehot_dec.sv | 19 +
 rtl/rf_write_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter: FSM state
// encoding, register-file geometry and a small state helper.
package rf_arb_pkg;

   localparam int RF_DEPTH = 8;
   localparam int RF_AW    = 3;
   localparam int RF_DW    = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR0    = 2'd1,
      ST_WR1_LO = 2'd2,
      ST_WR1_HI = 2'd3
   } rf_arb_state_e;

   // The high-byte cycle is already committed when we are in WR1_LO, so
   // that is the only state in which a new request cannot be taken.
   function automatic logic can_arbitrate(rf_arb_state_e s);
      return (s != ST_WR1_LO);
   endfunction

endpackage

// File: rtl/rf_onehot_dec.sv
// 3-to-8 one-hot decoder with enable; drives the register-file write
// enables so at most one register is written per cycle.
module rf_onehot_dec
   import rf_arb_pkg::*;
(
   input  logic                en_i,
   input  logic [RF_AW-1:0]    addr_i,
   output logic [RF_DEPTH-1:0] onehot_o
);

   // Single bit set at addr_i when enabled, all zeros otherwise.
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[addr_i] = 1'b1;
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin write arbiter for an 8x8 register file shared by an ALU
// (one byte per write) and a multiplier (two bytes on consecutive cycles).
// Optional feature: define RF_ARB_COLLISION_CNT_EN to add the saturating
// coll_cnt output counting grants issued while both requesters were active.
//
// Handshake: a transfer happens in any cycle where reqN and gntN are both
// high; gnt is combinational from the state, both reqs and the priority
// pointer, and addr/data are captured on that same rising edge. A req that
// stays high after its grant is simply a new request.
module rf_write_arbiter
   import rf_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic [RF_AW-1:0]      addr0,
   input  logic [RF_DW-1:0]      data0,
   output logic                  gnt0,
   input  logic                  req1,
   input  logic [RF_AW-1:0]      addr1,
   input  logic [2*RF_DW-1:0]    data1,
   output logic                  gnt1,
   output logic [RF_DEPTH-1:0]   rf_en,
   output logic [RF_DW-1:0]      rf_wdata,
   output logic                  busy,
   output rf_arb_state_e         state_o
`ifdef RF_ARB_COLLISION_CNT_EN
   ,
   output logic [7:0]            coll_cnt
`endif
);

   rf_arb_state_e        state_q;
   logic                 ptr_q;       // 0: req0 wins a tie, 1: req1 wins a tie
   logic [RF_AW-1:0]     addr0_q;
   logic [RF_DW-1:0]     data0_q;
   logic [RF_AW-1:0]     addr1_q;
   logic [2*RF_DW-1:0]   data1_q;

   logic                 wr_en;
   logic [RF_AW-1:0]     wr_addr;
   logic                 arb_ok;

   // Grant generation: only in arbitration states, one winner, ties by pointer.
   always_comb begin
      arb_ok = can_arbitrate(state_q) && !reset;
      gnt0   = arb_ok && req0 && (!req1 || !ptr_q);
      gnt1   = arb_ok && req1 && (!req0 ||  ptr_q);
   end

   // FSM, tie pointer and captured write operands.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
         addr0_q <= '0;
         data0_q <= '0;
         addr1_q <= '0;
         data1_q <= '0;
      end else if (gnt0) begin
         state_q <= ST_WR0;
         ptr_q   <= 1'b1;
         addr0_q <= addr0;
         data0_q <= data0;
      end else if (gnt1) begin
         state_q <= ST_WR1_LO;
         ptr_q   <= 1'b0;
         addr1_q <= addr1;
         data1_q <= data1;
      end else if (state_q == ST_WR1_LO) begin
         state_q <= ST_WR1_HI;
      end else begin
         state_q <= ST_IDLE;
      end
   end

   // Write-port selection from the current state; silenced during reset.
   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = '0;
      rf_wdata = '0;
      case (state_q)
         ST_WR0: begin
            wr_en    = 1'b1;
            wr_addr  = addr0_q;
            rf_wdata = data0_q;
         end
         ST_WR1_LO: begin
            wr_en    = 1'b1;
            wr_addr  = addr1_q;
            rf_wdata = data1_q[RF_DW-1:0];
         end
         ST_WR1_HI: begin
            wr_en    = 1'b1;
            wr_addr  = addr1_q + RF_AW'(1);   // wraps 7 -> 0
            rf_wdata = data1_q[2*RF_DW-1:RF_DW];
         end
         default: begin
            wr_en    = 1'b0;
         end
      endcase
      if (reset) begin
         wr_en    = 1'b0;
         rf_wdata = '0;
      end
   end

   rf_onehot_dec u_dec (
      .en_i     (wr_en),
      .addr_i   (wr_addr),
      .onehot_o (rf_en)
   );

   assign busy    = (state_q != ST_IDLE);
   assign state_o = state_q;

`ifdef RF_ARB_COLLISION_CNT_EN
   logic [7:0] coll_q;

   // Count grants made while both requesters contended, saturating at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         coll_q <= '0;
      end else if ((gnt0 || gnt1) && req0 && req1 && (coll_q != 8'hFF)) begin
         coll_q <= coll_q + 8'd1;
      end
   end

   assign coll_cnt = coll_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a queue-of-pending-byte-writes model.
module tb_rf_write_arbiter;
   import rf_arb_pkg::*;

   logic          clk;
   logic          reset;
   logic          req0;
   logic [2:0]    addr0;
   logic [7:0]    data0;
   logic          gnt0;
   logic          req1;
   logic [2:0]    addr1;
   logic [15:0]   data1;
   logic          gnt1;
   logic [7:0]    rf_en;
   logic [7:0]    rf_wdata;
   logic          busy;
   rf_arb_state_e dbg_state;
`ifdef RF_ARB_COLLISION_CNT_EN
   logic [7:0]    coll_cnt;
`endif

   rf_write_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .addr0    (addr0),
      .data0    (data0),
      .gnt0     (gnt0),
      .req1     (req1),
      .addr1    (addr1),
      .data1    (data1),
      .gnt1     (gnt1),
      .rf_en    (rf_en),
      .rf_wdata (rf_wdata),
      .busy     (busy),
      .state_o  (dbg_state)
`ifdef RF_ARB_COLLISION_CNT_EN
      ,
      .coll_cnt (coll_cnt)
`endif
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: each entry is {reg index[10:8], byte[7:0]} to be written on one
   // future cycle, oldest first; the head is the write visible this cycle.
   logic [10:0] exp_q[$];
   logic        pref1;     // 1 when requester 1 wins the next tie
   int          coll_m;
   int          n_checks;
   int          n_pass;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Driver + scoreboard for one clock cycle.
   task automatic step(input logic rst, input logic r0, input logic [2:0] a0,
                       input logic [7:0] d0, input logic r1, input logic [2:0] a1,
                       input logic [15:0] d1);
      logic       can, g0, g1;
      logic [7:0] e_en, e_wd;
      logic [2:0] hi_idx;
      reset = rst; req0 = r0; addr0 = a0; data0 = d0;
      req1 = r1; addr1 = a1; data1 = d1;
      #4;
      can  = (exp_q.size() <= 1) && !rst;
      g0   = can && r0 && (!r1 || !pref1);
      g1   = can && r1 && (!r0 ||  pref1);
      e_en = 8'h00;
      e_wd = 8'h00;
      if (exp_q.size() > 0 && !rst) begin
         e_en = 8'h01 << exp_q[0][10:8];
         e_wd = exp_q[0][7:0];
      end
      chk("gnt0", 16'(gnt0), 16'(g0));
      chk("gnt1", 16'(gnt1), 16'(g1));
      chk("rf_en", 16'(rf_en), 16'(e_en));
      chk("rf_wdata", 16'(rf_wdata), 16'(e_wd));
      chk("busy", 16'(busy), 16'(exp_q.size() != 0));
`ifdef RF_ARB_COLLISION_CNT_EN
      chk("coll_cnt", 16'(coll_cnt), 16'(coll_m));
`endif
      if (rst) begin
         exp_q.delete();
         pref1  = 1'b0;
         coll_m = 0;
      end else begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (g0) begin
            exp_q.push_back({a0, d0});
            pref1 = 1'b1;
         end
         if (g1) begin
            hi_idx = 3'((int'(a1) + 1) % 8);
            exp_q.push_back({a1, d1[7:0]});
            exp_q.push_back({hi_idx, d1[15:8]});
            pref1 = 1'b0;
         end
         if ((g0 || g1) && r0 && r1 && coll_m < 255) coll_m++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      pref1    = 1'b0;
      coll_m   = 0;
      reset = 1'b1; req0 = 1'b0; addr0 = '0; data0 = '0;
      req1 = 1'b0; addr1 = '0; data1 = '0;
      @(posedge clk);
      #1;
      step(1, 0, 0, 8'h00, 0, 0, 16'h0000);
      step(1, 1, 2, 8'h11, 1, 4, 16'h2222);   // grants held off during reset

      // Single ALU write to r3
      step(0, 1, 3, 8'hA5, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);

      // Multiplier write at r7 wrapping to r0; req0 ignored in low-byte cycle
      step(0, 0, 0, 8'h00, 1, 7, 16'h1234);
      step(0, 1, 5, 8'h5A, 0, 0, 16'h0000);
      step(0, 1, 5, 8'h5A, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);

      // Both held after reset: alternating grants, no bubbles
      step(1, 0, 0, 8'h00, 0, 0, 16'h0000);
      for (int i = 0; i < 9; i++) step(0, 1, 3'(i), 8'(8'h30 + i), 1, 3'(7 - i), 16'(16'hC000 + i));
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);

      // Reset during the low-byte cycle aborts the high byte
      step(0, 0, 0, 8'h00, 1, 2, 16'hBEEF);
      step(1, 0, 0, 8'h00, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);

      // ALU streaming r0..r7 with one write per cycle
      for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 8'(8'h80 + i), 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      end

      // Sustained contention to drive the collision count past saturation
      step(1, 0, 0, 8'h00, 0, 0, 16'h0000);
      for (int i = 0; i < 470; i++) begin
         step(0, 1, 3'($urandom_range(0, 7)), 8'($urandom),
              1, 3'($urandom_range(0, 7)), 16'($urandom));
      end
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);
      step(0, 0, 0, 8'h00, 0, 0, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
